// File: rtl/instr_streamer.sv
// instr_streamer: buffered instruction source for the core's instr_in/enable port.
// A program is loaded over a valid/ready port. On start it is issued one word
// per clock, held off by stall, and followed by DRAIN_CYCLES NOPs that flush
// the pipeline. After that, done pulses for one cycle.
// Optional feature: define INSTR_STREAMER_HAZARD_NOP_EN to insert one NOP after
// a lw whose destination register is read by the next buffered word.
module instr_streamer #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              clear,
    input  logic              start,
    input  logic              stall,
    output logic [31:0]       instr_out,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W:0]   rd;
    logic [DRN_W-1:0]  drn;
    logic [31:0]       rd_word;
    logic              last_word;
    logic              load_fire;
    logic              start_ok;

    assign rd_word   = mem[rd[ADDR_W-1:0]];
    assign last_word = (rd == count - (ADDR_W+1)'(1));
    assign start_ok  = start && (count != '0);

    // A pending start takes the cycle, so the load port backs off while start is high.
    assign load_ready = (state == IDLE) && (count < (ADDR_W+1)'(DEPTH)) && !start;
    assign load_fire  = load_valid && load_ready && !clear;

    // Program buffer write; contents survive reset and clear, only count is reset.
    always_ff @(posedge clk) begin
        if (load_fire)
            mem[count[ADDR_W-1:0]] <= load_data;
    end

`ifdef INSTR_STREAMER_HAZARD_NOP_EN
    logic              nop_pend;
    logic              hazard;
    logic [ADDR_W-1:0] nxt_idx;
    logic [5:0]        nxt_op;
    logic [4:0]        nxt_rs;
    logic [4:0]        nxt_rt;
    logic [4:0]        lw_rt;

    assign nxt_idx = rd[ADDR_W-1:0] + ADDR_W'(1);
    assign {nxt_op, nxt_rs, nxt_rt} = mem[nxt_idx][31:16];
    assign lw_rt = rd_word[20:16];

    // Load-use check: the word being issued is a lw and the following word reads its rt.
    always_comb begin
        hazard = 1'b0;
        if ((rd_word[31:26] == 6'b100011) && (lw_rt != 5'd0) && !last_word) begin
            if (nxt_rs == lw_rt)
                hazard = 1'b1;
            else if (((nxt_op == 6'b000000) || (nxt_op == 6'b101011)) && (nxt_rt == lw_rt))
                hazard = 1'b1;
        end
    end

    // One-shot NOP request raised by a hazardous lw issue, consumed by the next unstalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nop_pend <= 1'b0;
        else if (state == RUN && !stall)
            nop_pend <= !nop_pend && hazard;
        else if (state != RUN)
            nop_pend <= 1'b0;
    end
`else
    logic nop_pend;
    assign nop_pend = 1'b0;
`endif

    // Main control FSM with registered issue outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            rd        <= '0;
            drn       <= '0;
            instr_out <= 32'h0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state == RUN) || (state == DRAIN);
            case (state)
                IDLE: begin
                    enable <= 1'b0;
                    if (start_ok) begin
                        state <= RUN;
                        rd    <= '0;
                        drn   <= '0;
                    end else if (clear) begin
                        count <= '0;
                    end else if (load_fire) begin
                        count <= count + (ADDR_W+1)'(1);
                    end
                end
                RUN: begin
                    if (stall) begin
                        enable <= 1'b0;
                    end else if (nop_pend) begin
                        instr_out <= 32'h0;
                        enable    <= 1'b1;
                    end else begin
                        instr_out <= rd_word;
                        enable    <= 1'b1;
                        rd        <= rd + (ADDR_W+1)'(1);
                        if (last_word) begin
                            state <= DRAIN;
                            drn   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (stall) begin
                        enable <= 1'b0;
                    end else begin
                        instr_out <= 32'h0;
                        enable    <= 1'b1;
                        drn       <= drn + DRN_W'(1);
                        if (drn == DRN_W'(DRAIN_CYCLES - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    enable <= 1'b0;
                    done   <= 1'b1;
                    rd     <= '0;
                    state  <= IDLE;
                end
                default: begin
                    enable <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
